alu_seq_core: RTL and testbench
===============================

Name: alu_seq_core

Overview:
- Multi-cycle ALU that sits directly upstream of the ALU output register.
- Latches operands A and B from the shared data bus and executes an opcode on a start pulse.
- Single-cycle ops finish in one cycle. Shifts run one bit per cycle; multiply runs shift-add.
- On completion, presents a registered result on alu_out and pulses load_out, which drives the output register's load input directly.

Parameters:
WIDTH, 32, datapath width.
SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).
MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as illegal.

Ports:
clk  input  1  clock. Everything is rising-edge.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
bus_in  input  WIDTH  operand source (shared data bus).
load_a  input  1  capture bus_in into A.
load_b  input  1  capture bus_in into B.
op  input  4  opcode, sampled with start.
start  input  1  begin operation (accepted only in IDLE).
alu_out  output  WIDTH  registered result; connects to the output register's data input.
load_out  output  1  one-cycle pulse when alu_out is newly valid.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse, coincident with load_out.
flags  output  4  {N,Z,C,V} of the last result.
err  output  1  last op was illegal; sticky until next accepted start.

Behaviour:
- Reset: rst_n=0 at an edge forces the following, taking priority over all other inputs, including mid-operation:
  - state=IDLE; A, B, alu_out, flags = 0; load_out, done, busy, err = 0.
  - Any partial result is discarded and no load_out is issued.
- Operand load: load_a/load_b take effect only in IDLE; ignored while busy.
  - Both may be asserted in the same cycle; both registers capture bus_in.
  - If asserted in the same cycle as an accepted start, the op uses the pre-edge A/B values; the new values land for the next op.
- Start: accepted when state=IDLE and start=1. op, A and B are copied into working registers at that edge. start while busy is ignored (no queuing).
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 10 PASS A, 11 PASS B.
  - 6 SLL, 7 SRL, 8 SRA, each by B[SHAMT_W-1:0].
  - 9 MUL: low WIDTH bits of A*B, unsigned.
  - 12-15 illegal: result 0, err=1.
- States:
  - IDLE: busy=0; on accepted start go to one of:
    - SHIFT, for op 6-8 with shamt>0.
    - MUL, for op 9 with MUL_EN=1.
    - DONE, for everything else; the result is computed combinationally and registered at this edge.
  - SHIFT: one bit position per cycle, with a down-counter from shamt. Go to DONE when the counter reaches 1 (the last bit shifts on that edge).
  - MUL: 32 iterations of shift-add over a WIDTH-bit accumulator, with overflow beyond WIDTH bits discarded. Go to DONE after iteration WIDTH.
  - DONE: alu_out/flags hold the final result; load_out=done=1 for exactly this cycle; next state IDLE unconditionally.
- Latency, with start accepted at edge t:
  - Single-cycle ops and zero shifts: DONE in cycle t+1.
  - Shift by k (k>0): DONE in cycle t+1+k.
  - MUL: DONE in cycle t+1+WIDTH.
- Back-to-back: the earliest next accepted start is the edge after DONE (one IDLE cycle minimum).
- alu_out holds the last result between operations. It never changes except on the edge entering DONE, or on reset.
- Flags, updated on the edge entering DONE:
  - Z = (result==0); N = result[WIDTH-1].
  - C = carry out for ADD, or no-borrow (A>=B unsigned) for SUB; V = signed overflow for ADD/SUB.
  - C and V are 0 for all other ops.
- err is set in DONE for illegal ops (including MUL when MUL_EN=0) and cleared on the next accepted start.
- SRA replicates A[WIDTH-1]. Shifting by WIDTH-1 is legal; the shamt field cannot exceed WIDTH-1.

Test Plan:
- Reset, load A=0x7FFFFFFF, B=1, start op=ADD -> DONE cycle t+1: alu_out=0x80000000, load_out=1 for one cycle, flags N=1 Z=0 C=0 V=1.
- A=5, B=5, op=SUB -> alu_out=0, Z=1, C=1, V=0; then A=0, B=1, SUB -> alu_out=0xFFFFFFFF, N=1, C=0.
- A=0x80000000, B=4, op=SRA -> busy for 4 SHIFT cycles, DONE at t+5, alu_out=0xF8000000; same with SRL -> 0x08000000; shamt=0 -> DONE at t+1, alu_out=A.
- A=0x00012345, B=0x00010000, op=MUL -> done at t+33, alu_out=0x23450000.
  - start and load_a pulses mid-MUL are ignored: result unchanged and A not updated.
- Start MUL, assert rst_n=0 at cycle t+10 -> next cycle busy=0, alu_out=0, no load_out pulse ever; op=13 -> DONE at t+1, alu_out=0, err=1 until next start.

Source files
------------

// File: rtl/alu_seq_core_if.sv
// Handshake and data bundle between the ALU sequencer and whoever drives it.
// The master side feeds operands, opcode and start; the slave side (the ALU)
// returns the registered result and status.
interface alu_seq_core_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] bus_in;
  logic             load_a;
  logic             load_b;
  logic [3:0]       op;
  logic             start;
  logic [WIDTH-1:0] alu_out;
  logic             load_out;
  logic             busy;
  logic             done;
  logic [3:0]       flags;
  logic             err;

  modport master (
    output bus_in, load_a, load_b, op, start,
    input  alu_out, load_out, busy, done, flags, err
  );

  modport slave (
    input  bus_in, load_a, load_b, op, start,
    output alu_out, load_out, busy, done, flags, err
  );
endinterface

// File: rtl/alu_seq_core.sv
// Multi-cycle ALU feeding the output register. Logic/arithmetic ops complete
// in one cycle, shifts move one bit per cycle and multiply is shift-add.
// Every result, flag and strobe is registered; the result register only
// changes on the edge that enters DONE.
module alu_seq_core #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int MUL_EN  = 1
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_core_if.slave bus
);

  // Counter must hold both a shift amount and the WIDTH multiply iterations
  localparam int CNT_W = SHAMT_W + 1;
  localparam int MSB   = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_PASA = 4'd10;
  localparam logic [3:0] OP_PASB = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_MUL,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       op_w;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic             illegal;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] mul_sum;
  logic             is_shift;
  logic [SHAMT_W-1:0] shamt;

  // Single-cycle result and flags from the operands held before the start edge
  always_comb begin
    sum_ext = {1'b0, a_reg} + {1'b0, b_reg};
    diff    = a_reg - b_reg;
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    illegal = 1'b0;
    case (bus.op)
      OP_ADD: begin
        res   = sum_ext[MSB:0];
        res_c = sum_ext[WIDTH];
        res_v = (a_reg[MSB] == b_reg[MSB]) && (sum_ext[MSB] != a_reg[MSB]);
      end
      OP_SUB: begin
        res   = diff;
        res_c = (a_reg >= b_reg);
        res_v = (a_reg[MSB] != b_reg[MSB]) && (diff[MSB] != a_reg[MSB]);
      end
      OP_AND:  res = a_reg & b_reg;
      OP_OR:   res = a_reg | b_reg;
      OP_XOR:  res = a_reg ^ b_reg;
      OP_NOT:  res = ~a_reg;
      OP_SLL, OP_SRL, OP_SRA: res = a_reg;
      OP_MUL: begin
        if (MUL_EN == 0) begin
          illegal = 1'b1;
        end
      end
      OP_PASA: res = a_reg;
      OP_PASB: res = b_reg;
      default: illegal = 1'b1;
    endcase
  end

  // Next values for the iterative shifter and the shift-add multiplier
  always_comb begin
    shamt    = b_reg[SHAMT_W-1:0];
    is_shift = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);
    case (op_w)
      OP_SLL:  shift_next = {work[MSB-1:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, work[MSB:1]};
      default: shift_next = {work[MSB], work[MSB:1]};
    endcase
    mul_sum = acc + (mplr[0] ? work : '0);
  end

  // Sequencer: operand capture, op dispatch, iteration and result registering
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      op_w         <= '0;
      work         <= '0;
      mplr         <= '0;
      acc          <= '0;
      cnt          <= '0;
      bus.alu_out  <= '0;
      bus.flags    <= '0;
      bus.load_out <= 1'b0;
      bus.done     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.load_out <= 1'b0;
      bus.done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.load_a) a_reg <= bus.bus_in;
          if (bus.load_b) b_reg <= bus.bus_in;
          if (bus.start) begin
            op_w     <= bus.op;
            work     <= a_reg;
            mplr     <= b_reg;
            bus.busy <= 1'b1;
            bus.err  <= 1'b0;
            if (is_shift && (shamt != '0)) begin
              cnt   <= {1'b0, shamt};
              state <= S_SHIFT;
            end else if ((bus.op == OP_MUL) && (MUL_EN != 0)) begin
              acc   <= '0;
              cnt   <= CNT_W'(WIDTH);
              state <= S_MUL;
            end else begin
              bus.alu_out  <= res;
              bus.flags    <= {res[MSB], (res == '0), res_c, res_v};
              bus.err      <= illegal;
              bus.load_out <= 1'b1;
              bus.done     <= 1'b1;
              state        <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          work <= shift_next;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            bus.alu_out  <= shift_next;
            bus.flags    <= {shift_next[MSB], (shift_next == '0), 2'b00};
            bus.load_out <= 1'b1;
            bus.done     <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_MUL: begin
          acc  <= mul_sum;
          work <= {work[MSB-1:0], 1'b0};
          mplr <= {1'b0, mplr[MSB:1]};
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            bus.alu_out  <= mul_sum;
            bus.flags    <= {mul_sum[MSB], (mul_sum == '0), 2'b00};
            bus.load_out <= 1'b1;
            bus.done     <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core with hand-computed results, flags and
// latencies, including ignored mid-operation inputs and reset during MUL.
module tb_alu_seq_core;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_core_if #(.WIDTH(WIDTH)) bus_if ();

  alu_seq_core #(
    .WIDTH(WIDTH),
    .SHAMT_W(5),
    .MUL_EN(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int errorCount = 0;
  int checkCount = 0;
  int cycleCount = 0;
  int startCycle = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cycleCount++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic startOp(input logic [3:0] opc);
    bus_if.op    = opc;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    startCycle   = cycleCount;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] opc);
    bus_if.bus_in = a;
    bus_if.load_a = 1'b1;
    tick();
    bus_if.load_a = 1'b0;
    bus_if.bus_in = b;
    bus_if.load_b = 1'b1;
    tick();
    bus_if.load_b = 1'b0;
    startOp(opc);
  endtask

  task automatic waitDone(output int lat);
    int guard = 0;
    while (bus_if.done !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    if (bus_if.done !== 1'b1) begin
      checkOutput("done timeout", {31'b0, bus_if.done}, 32'd1);
      lat = -1;
    end else begin
      lat = cycleCount - startCycle + 1;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] opc, input int expLat, input logic [31:0] expRes,
                       input logic [3:0] expFlags, input logic expErr);
    int lat;
    applyStimulus(a, b, opc);
    checkOutput({tag, " busy"}, {31'b0, bus_if.busy}, 32'd1);
    waitDone(lat);
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " alu_out"}, bus_if.alu_out, expRes);
    checkOutput({tag, " flags"}, {28'b0, bus_if.flags}, {28'b0, expFlags});
    checkOutput({tag, " load_out"}, {31'b0, bus_if.load_out}, 32'd1);
    checkOutput({tag, " err"}, {31'b0, bus_if.err}, {31'b0, expErr});
    tick();
    checkOutput({tag, " load_out drop"}, {31'b0, bus_if.load_out}, 32'd0);
    checkOutput({tag, " idle"}, {31'b0, bus_if.busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    bus_if.bus_in = '0;
    bus_if.load_a = 1'b0;
    bus_if.load_b = 1'b0;
    bus_if.op     = '0;
    bus_if.start  = 1'b0;

    rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset busy", {31'b0, bus_if.busy}, 32'd0);
    checkOutput("reset alu_out", bus_if.alu_out, 32'd0);
    checkOutput("reset flags", {28'b0, bus_if.flags}, 32'd0);
    checkOutput("reset err", {31'b0, bus_if.err}, 32'd0);
    checkOutput("reset load_out", {31'b0, bus_if.load_out}, 32'd0);
    checkOutput("reset done", {31'b0, bus_if.done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Arithmetic with flag corner cases
    runOp("add ovf", 32'h7FFF_FFFF, 32'h0000_0001, 4'd0, 1, 32'h8000_0000, 4'b1001, 1'b0);
    runOp("add carry", 32'hFFFF_FFFF, 32'h0000_0001, 4'd0, 1, 32'h0000_0000, 4'b0110, 1'b0);
    runOp("sub eq", 32'd5, 32'd5, 4'd1, 1, 32'h0000_0000, 4'b0110, 1'b0);
    runOp("sub borrow", 32'd0, 32'd1, 4'd1, 1, 32'hFFFF_FFFF, 4'b1000, 1'b0);

    // Logic and pass-through ops
    runOp("and", 32'hF0F0_1234, 32'h0FF0_00FF, 4'd2, 1, 32'h00F0_0034, 4'b0000, 1'b0);
    runOp("or", 32'hF0F0_1234, 32'h0FF0_00FF, 4'd3, 1, 32'hFFF0_12FF, 4'b1000, 1'b0);
    runOp("xor", 32'hF0F0_1234, 32'h0FF0_00FF, 4'd4, 1, 32'hFF00_12CB, 4'b1000, 1'b0);
    runOp("not", 32'hF0F0_1234, 32'h0FF0_00FF, 4'd5, 1, 32'h0F0F_EDCB, 4'b0000, 1'b0);
    runOp("passb", 32'hF0F0_1234, 32'h0FF0_00FF, 4'd11, 1, 32'h0FF0_00FF, 4'b0000, 1'b0);

    // Shifts: multi-cycle latency, zero shift and the maximum amount
    runOp("sra4", 32'h8000_0000, 32'd4, 4'd8, 5, 32'hF800_0000, 4'b1000, 1'b0);
    runOp("srl4", 32'h8000_0000, 32'd4, 4'd7, 5, 32'h0800_0000, 4'b0000, 1'b0);
    runOp("sra0", 32'h8000_0000, 32'd0, 4'd8, 1, 32'h8000_0000, 4'b1000, 1'b0);
    runOp("sll31", 32'h0000_0001, 32'd31, 4'd6, 32, 32'h8000_0000, 4'b1000, 1'b0);

    // Multiply with ignored start/load_a in the middle
    applyStimulus(32'h0001_2345, 32'h0001_0000, 4'd9);
    checkOutput("mul busy", {31'b0, bus_if.busy}, 32'd1);
    repeat (4) tick();
    bus_if.bus_in = 32'hDEAD_BEEF;
    bus_if.load_a = 1'b1;
    bus_if.op     = 4'd0;
    bus_if.start  = 1'b1;
    tick();
    bus_if.load_a = 1'b0;
    bus_if.start  = 1'b0;
    waitDone(lat);
    checkOutput("mul latency", lat, 32'd33);
    checkOutput("mul alu_out", bus_if.alu_out, 32'h2345_0000);
    checkOutput("mul flags", {28'b0, bus_if.flags}, 32'd0);
    tick();
    startOp(4'd10);
    waitDone(lat);
    checkOutput("a kept latency", lat, 32'd1);
    checkOutput("a kept after mul", bus_if.alu_out, 32'h0001_2345);
    tick();

    // Reset in the middle of a multiply
    applyStimulus(32'd3, 32'd3, 4'd9);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midreset busy", {31'b0, bus_if.busy}, 32'd0);
    checkOutput("midreset alu_out", bus_if.alu_out, 32'd0);
    checkOutput("midreset flags", {28'b0, bus_if.flags}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.load_out === 1'b1) pulses++;
      tick();
    end
    checkOutput("midreset no load_out", pulses, 32'd0);

    // Illegal opcode: sticky err until the next accepted start
    startOp(4'd13);
    waitDone(lat);
    checkOutput("illegal latency", lat, 32'd1);
    checkOutput("illegal alu_out", bus_if.alu_out, 32'd0);
    checkOutput("illegal err", {31'b0, bus_if.err}, 32'd1);
    checkOutput("illegal flags", {28'b0, bus_if.flags}, {28'b0, 4'b0100});
    repeat (4) tick();
    checkOutput("illegal err sticky", {31'b0, bus_if.err}, 32'd1);
    runOp("add clears err", 32'd2, 32'd3, 4'd0, 1, 32'd5, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
